// File: rtl/bg_cfg_arbiter_if.sv
// Bus between the control FSMs and the background colour arbiter.
// The FSMs (master) raise update requests with per-requester colour slices.
// The arbiter (slave) returns the acknowledge, the commit status and the active colours.
interface bg_cfg_arbiter_if #(
  parameter int N_REQ = 2
);
  logic                  vblnk;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*12-1:0]   cfg_felt;
  logic [N_REQ*12-1:0]   cfg_border;
  logic [N_REQ*12-1:0]   cfg_outer;
  logic [N_REQ-1:0]      ack;
  logic                  commit_done;
  logic                  pending;
  logic [11:0]           felt_rgb;
  logic [11:0]           border_rgb;
  logic [11:0]           outer_rgb;
  logic [15:0]           frame_cnt;

  modport master (
    output vblnk, req, cfg_felt, cfg_border, cfg_outer,
    input  ack, commit_done, pending, felt_rgb, border_rgb, outer_rgb, frame_cnt
  );

  modport slave (
    input  vblnk, req, cfg_felt, cfg_border, cfg_outer,
    output ack, commit_done, pending, felt_rgb, border_rgb, outer_rgb, frame_cnt
  );
endinterface

// File: rtl/bg_cfg_arbiter.sv
// Background colour configuration owner.
// Update requests are arbitrated round-robin, and the winner's colours are latched into a shadow register.
// The shadow is copied to the active colours only after a rising edge of vblnk, so the drawing stage never sees a mid-frame change.
module bg_cfg_arbiter #(
  parameter int          N_REQ      = 2,
  parameter logic [11:0] DEF_FELT   = 12'h0a0,
  parameter logic [11:0] DEF_BORDER = 12'hfa5,
  parameter logic [11:0] DEF_OUTER  = 12'h080
) (
  input  logic               clk,
  input  logic               rst,
  bg_cfg_arbiter_if.slave    bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_vblnk_d;
  logic               w_vb_rise;
  logic [15:0]        r_frame_cnt;

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_ptr_nxt;
  logic [N_REQ-1:0]   w_req_rot;
  logic               w_found;
  int                 w_win;
  logic [N_REQ-1:0]   w_ack_nxt;
  logic [11:0]        w_sel_felt;
  logic [11:0]        w_sel_border;
  logic [11:0]        w_sel_outer;

  logic               w_take;
  logic               w_commit;

  logic [N_REQ-1:0]   r_ack;
  logic               r_commit_done;
  logic               r_pending;
  logic [11:0]        r_sh_felt;
  logic [11:0]        r_sh_border;
  logic [11:0]        r_sh_outer;
  logic [11:0]        r_felt;
  logic [11:0]        r_border;
  logic [11:0]        r_outer;

  assign w_vb_rise = bus.vblnk & ~r_vblnk_d;

  // Round-robin winner: rotate req so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_req_rot    = N_REQ'({bus.req, bus.req} >> r_rr_ptr);
    w_found      = 1'b0;
    w_win        = 0;
    w_ack_nxt    = '0;
    w_rr_ptr_nxt = r_rr_ptr;
    w_sel_felt   = '0;
    w_sel_border = '0;
    w_sel_outer  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_win   = (int'(r_rr_ptr) + k) % N_REQ;
      end
    end
    if (w_found) begin
      w_ack_nxt    = N_REQ'(1) << w_win;
      w_rr_ptr_nxt = PTR_W'((w_win + 1) % N_REQ);
      w_sel_felt   = 12'(bus.cfg_felt   >> (12 * w_win));
      w_sel_border = 12'(bus.cfg_border >> (12 * w_win));
      w_sel_outer  = 12'(bus.cfg_outer  >> (12 * w_win));
    end
  end

  // FSM next state. Acceptance is only possible in IDLE, and a vb_rise only matters in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_take      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_vb_rise) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // vblnk edge history and frame counter.
  // The history resets high so a vblnk already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d   <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_vblnk_d <= bus.vblnk;
      if (w_vb_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Handshake pulses, round-robin pointer and shadow capture of the winner's colours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack         <= '0;
      r_commit_done <= 1'b0;
      r_pending     <= 1'b0;
      r_rr_ptr      <= '0;
      r_sh_felt     <= DEF_FELT;
      r_sh_border   <= DEF_BORDER;
      r_sh_outer    <= DEF_OUTER;
    end else begin
      r_ack         <= w_take ? w_ack_nxt : '0;
      r_commit_done <= w_commit;
      if (w_take) begin
        r_pending   <= 1'b1;
        r_rr_ptr    <= w_rr_ptr_nxt;
        r_sh_felt   <= w_sel_felt;
        r_sh_border <= w_sel_border;
        r_sh_outer  <= w_sel_outer;
      end else if (w_commit) begin
        r_pending   <= 1'b0;
      end
    end
  end

  // Active colours: loaded from the shadow only when leaving COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_felt   <= DEF_FELT;
      r_border <= DEF_BORDER;
      r_outer  <= DEF_OUTER;
    end else if (w_commit) begin
      r_felt   <= r_sh_felt;
      r_border <= r_sh_border;
      r_outer  <= r_sh_outer;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.commit_done = r_commit_done;
  assign bus.pending     = r_pending;
  assign bus.felt_rgb    = r_felt;
  assign bus.border_rgb  = r_border;
  assign bus.outer_rgb   = r_outer;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_bg_cfg_arbiter.sv
// Directed testbench for bg_cfg_arbiter with two requesters.
module tb_bg_cfg_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_commit;
  int   c0;

  bg_cfg_arbiter_if #(.N_REQ(2)) bus ();

  bg_cfg_arbiter #(.N_REQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count commit_done pulses away from the active edge.
  initial n_commit = 0;
  always @(negedge clk) if (bus.commit_done === 1'b1) n_commit++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int i, input logic [11:0] f, input logic [11:0] b, input logic [11:0] o);
    bus.cfg_felt[i*12 +: 12]   = f;
    bus.cfg_border[i*12 +: 12] = b;
    bus.cfg_outer[i*12 +: 12]  = o;
  endtask

  task automatic check_colours(input string tag, input logic [11:0] f, input logic [11:0] b, input logic [11:0] o);
    check_eq({tag, "_felt"},   32'(bus.felt_rgb),   32'(f));
    check_eq({tag, "_border"}, 32'(bus.border_rgb), 32'(b));
    check_eq({tag, "_outer"},  32'(bus.outer_rgb),  32'(o));
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.vblnk      = 1'b1;
    bus.req        = '0;
    bus.cfg_felt   = '0;
    bus.cfg_border = '0;
    bus.cfg_outer  = '0;
    repeat (3) tick();

    // Reset state, vblnk held high: no edge, no activity.
    rst = 1'b0;
    repeat (10) tick();
    check_colours("rst", 12'h0a0, 12'hfa5, 12'h080);
    check_eq("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_pending", 32'(bus.pending), 32'd0);
    check_eq("rst_commits", 32'(n_commit), 32'd0);

    // Single request from requester 0, commit after the next vblnk rise.
    bus.vblnk = 1'b0;
    set_cfg(0, 12'hf00, 12'h00f, 12'h111);
    bus.req = 2'b01;
    tick();
    check_eq("t2_ack", 32'(bus.ack), 32'h1);
    check_eq("t2_pending", 32'(bus.pending), 32'd1);
    bus.req = 2'b00;
    repeat (20) tick();
    check_eq("t2_ack_clear", 32'(bus.ack), 32'd0);
    check_colours("t2_hold", 12'h0a0, 12'hfa5, 12'h080);
    check_eq("t2_no_commit", 32'(n_commit), 32'd0);
    bus.vblnk = 1'b1;
    tick();
    check_eq("t2_e1_frame", 32'(bus.frame_cnt), 32'd1);
    check_eq("t2_e1_felt", 32'(bus.felt_rgb), 32'h0a0);
    check_eq("t2_e1_pending", 32'(bus.pending), 32'd1);
    tick();
    check_colours("t2_e2", 12'hf00, 12'h00f, 12'h111);
    check_eq("t2_commit_done", 32'(bus.commit_done), 32'd1);
    check_eq("t2_pending_drop", 32'(bus.pending), 32'd0);
    tick();
    check_eq("t2_commit_pulse", 32'(bus.commit_done), 32'd0);
    check_eq("t2_commit_cnt", 32'(n_commit), 32'd1);

    // Simultaneous requests right after reset: requester 0 first, requester 1 after the commit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.vblnk = 1'b0;
    set_cfg(0, 12'h123, 12'h456, 12'h789);
    set_cfg(1, 12'h321, 12'h654, 12'h987);
    bus.req = 2'b11;
    tick();
    check_eq("t3_ack0", 32'(bus.ack), 32'h1);
    bus.req = 2'b10;
    tick();
    check_eq("t3_hold_ack", 32'(bus.ack), 32'd0);
    tick();
    check_eq("t3_hold_ack2", 32'(bus.ack), 32'd0);
    bus.vblnk = 1'b1;
    tick();
    check_eq("t3_commit_ack", 32'(bus.ack), 32'd0);
    tick();
    check_colours("t3_first", 12'h123, 12'h456, 12'h789);
    check_eq("t3_first_done", 32'(bus.commit_done), 32'd1);
    check_eq("t3_first_ack", 32'(bus.ack), 32'd0);
    tick();
    check_eq("t3_ack1", 32'(bus.ack), 32'h2);
    set_cfg(1, 12'h000, 12'h000, 12'h000);
    bus.req = 2'b00;
    bus.vblnk = 1'b0;
    repeat (2) tick();
    check_colours("t3_wait", 12'h123, 12'h456, 12'h789);
    bus.vblnk = 1'b1;
    tick();
    tick();
    check_colours("t3_second", 12'h321, 12'h654, 12'h987);
    check_eq("t3_frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Acceptance coinciding with a vblnk rise: that edge is not used for the commit.
    bus.vblnk = 1'b0;
    tick();
    set_cfg(0, 12'h5a5, 12'h0f0, 12'h00f);
    bus.req = 2'b01;
    bus.vblnk = 1'b1;
    tick();
    check_eq("t4_ack", 32'(bus.ack), 32'h1);
    check_eq("t4_frame_a", 32'(bus.frame_cnt), 32'd3);
    bus.req = 2'b00;
    c0 = n_commit;
    repeat (2) tick();
    check_eq("t4_no_commit", 32'(n_commit), 32'(c0));
    check_eq("t4_old_felt", 32'(bus.felt_rgb), 32'h321);
    check_eq("t4_pending", 32'(bus.pending), 32'd1);
    bus.vblnk = 1'b0;
    tick();
    bus.vblnk = 1'b1;
    tick();
    check_eq("t4_frame_b", 32'(bus.frame_cnt), 32'd4);
    tick();
    check_colours("t4_commit", 12'h5a5, 12'h0f0, 12'h00f);
    check_eq("t4_commit_done", 32'(bus.commit_done), 32'd1);

    // Reset while HOLD carries a pending update: shadow discarded, no later commit.
    bus.vblnk = 1'b0;
    tick();
    set_cfg(0, 12'habc, 12'habc, 12'habc);
    bus.req = 2'b01;
    tick();
    check_eq("t5_ack", 32'(bus.ack), 32'h1);
    bus.req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_colours("t5_rst", 12'h0a0, 12'hfa5, 12'h080);
    check_eq("t5_pending", 32'(bus.pending), 32'd0);
    check_eq("t5_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    c0 = n_commit;
    tick();
    bus.vblnk = 1'b1;
    repeat (3) tick();
    check_eq("t5_no_commit", 32'(n_commit), 32'(c0));
    check_eq("t5_felt", 32'(bus.felt_rgb), 32'h0a0);
    check_eq("t5_frame_one", 32'(bus.frame_cnt), 32'd1);

    // Frame counter wrap: preload near the top to keep the run short.
    bus.vblnk = 1'b0;
    tick();
    force dut.r_frame_cnt = 16'hfffe;
    #1;
    release dut.r_frame_cnt;
    bus.vblnk = 1'b1;
    tick();
    check_eq("t6_ffff", 32'(bus.frame_cnt), 32'hffff);
    bus.vblnk = 1'b0;
    tick();
    bus.vblnk = 1'b1;
    tick();
    check_eq("t6_wrap", 32'(bus.frame_cnt), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
